// File: rtl/io_channel_bank.sv
// Peripheral-side channel register bank for the core IO port: eight 15-bit
// channels, a queued output-event FIFO, and a peripheral input load port.
module io_channel_bank #(
  parameter int         DEPTH    = 4,
  parameter logic [7:0] OUT_MASK = 8'b0000_1111,
  parameter logic [7:0] IN_MASK  = 8'b0011_0000
) (
  input  logic        clock,
  input  logic        rst_l,
  input  logic [2:0]  io_read_sel,
  output logic [14:0] io_read_data,
  input  logic [2:0]  io_write_sel,
  input  logic [14:0] io_write_data,
  input  logic        io_write_en,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  out_sel,
  output logic [14:0] out_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_sel,
  input  logic [14:0] in_data,
  output logic        ovf,
  input  logic        ovf_clear
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [14:0]   chan       [8];
  logic [2:0]    fifo_sel   [DEPTH];
  logic [14:0]   fifo_data  [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;

  logic push_req;
  logic push;
  logic pop;
  logic drop;
  logic in_load;
  logic full;

  assign io_read_data = chan[io_read_sel];
  assign out_valid    = (count != {(AW + 1){1'b0}});
  assign full         = (count == FULL_COUNT);
  assign in_ready     = !(io_write_en && (io_write_sel == in_sel));

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    push_req = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    drop     = 1'b0;
    in_load  = 1'b0;
    pop      = out_valid && out_ready;
    push_req = io_write_en && OUT_MASK[io_write_sel];
    if (push_req) begin
      push = !full || pop;
      drop = full && !pop;
    end else begin
      push = 1'b0;
      drop = 1'b0;
    end
    in_load = in_valid && in_ready && IN_MASK[in_sel];
  end

  // Head entry is forced to zero while empty so stale slots never leak out.
  always_comb begin
    out_sel  = 3'd0;
    out_data = 15'd0;
    if (out_valid) begin
      out_sel  = fifo_sel[rd_ptr];
      out_data = fifo_data[rd_ptr];
    end else begin
      out_sel  = 3'd0;
      out_data = 15'd0;
    end
  end

  // Channel registers; in_ready guarantees the two writers hit different channels.
  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < 8; i++) begin
        chan[i] <= 15'd0;
      end
    end else begin
      if (io_write_en) begin
        chan[io_write_sel] <= io_write_data;
      end
      if (in_load) begin
        chan[in_sel] <= in_data;
      end
    end
  end

  // Output event storage.
  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_sel[i]  <= 3'd0;
        fifo_data[i] <= 15'd0;
      end
    end else if (push) begin
      fifo_sel[wr_ptr]  <= io_write_sel;
      fifo_data[wr_ptr] <= io_write_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      rd_ptr <= {AW{1'b0}};
      wr_ptr <= {AW{1'b0}};
      count  <= {(AW + 1){1'b0}};
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + {{(AW - 1){1'b0}}, 1'b1};
      end
      if (pop) begin
        rd_ptr <= rd_ptr + {{(AW - 1){1'b0}}, 1'b1};
      end
      case ({push, pop})
        2'b10:   count <= count + {{AW{1'b0}}, 1'b1};
        2'b01:   count <= count - {{AW{1'b0}}, 1'b1};
        default: count <= count;
      endcase
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear wins.
  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (ovf_clear) begin
      ovf <= 1'b0;
    end else begin
      ovf <= ovf;
    end
  end

endmodule

// File: tb/tb_io_channel_bank.sv
// Directed scoreboard bench for io_channel_bank: expected out events are
// queued as writes are driven and compared as the peripheral pops them.
module tb_io_channel_bank;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        rst_l;
  logic [2:0]  io_read_sel;
  logic [14:0] io_read_data;
  logic [2:0]  io_write_sel;
  logic [14:0] io_write_data;
  logic        io_write_en;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_sel;
  logic [14:0] out_data;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_sel;
  logic [14:0] in_data;
  logic        ovf;
  logic        ovf_clear;

  int vectors = 0;
  int miscompares = 0;
  logic [17:0] exp_q[$];

  io_channel_bank #(.DEPTH(DEPTH)) dut (
    .clock(clock), .rst_l(rst_l),
    .io_read_sel(io_read_sel), .io_read_data(io_read_data),
    .io_write_sel(io_write_sel), .io_write_data(io_write_data), .io_write_en(io_write_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel), .out_data(out_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .ovf(ovf), .ovf_clear(ovf_clear)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ev(input logic [2:0] s, input logic [14:0] d);
    return 32'({s, d});
  endfunction

  task automatic rd(input string tag, input logic [2:0] s, input logic [14:0] exp);
    io_read_sel = s;
    #1;
    check(tag, 32'(io_read_data), 32'(exp));
  endtask

  // Score the pop and the push implied by the current inputs, then clock once.
  task automatic tick();
    logic [17:0] e;
    bit pop;
    pop = out_valid && out_ready;
    if (pop) begin
      if (exp_q.size() == 0) begin
        check("spurious_pop", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("out_event", ev(out_sel, out_data), 32'(e));
      end
    end
    if (io_write_en && io_write_sel <= 3'd3 && exp_q.size() < DEPTH) begin
      exp_q.push_back({io_write_sel, io_write_data});
    end
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [2:0] s, input logic [14:0] d);
    io_write_en = 1'b1; io_write_sel = s; io_write_data = d;
    tick();
    io_write_en = 1'b0;
  endtask

  initial begin
    rst_l = 1'b0; io_read_sel = 3'd0; io_write_sel = 3'd0; io_write_data = 15'd0;
    io_write_en = 1'b0; out_ready = 1'b0; in_valid = 1'b0; in_sel = 3'd0;
    in_data = 15'd0; ovf_clear = 1'b0;
    #12;
    rst_l = 1'b1;
    #1;
    // Reset state
    for (int i = 0; i < 8; i++) rd("reset_chan", 3'(i), 15'd0);
    check("reset_out_valid", 32'(out_valid), 32'(0));
    check("reset_ovf", 32'(ovf), 32'(0));
    check("reset_in_ready", 32'(in_ready), 32'(1));

    // Test 1: single write, no bypass, one-cycle latency, drain
    io_write_en = 1'b1; io_write_sel = 3'd2; io_write_data = 15'o12345;
    rd("no_bypass", 3'd2, 15'd0);
    tick();
    io_write_en = 1'b0;
    rd("t1_chan2", 3'd2, 15'o12345);
    check("t1_out_valid", 32'(out_valid), 32'(1));
    check("t1_head", ev(out_sel, out_data), ev(3'd2, 15'o12345));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t1_empty", 32'(out_valid), 32'(0));
    check("t1_empty_head", ev(out_sel, out_data), 32'(0));

    // Test 2: fill, drop, hold stable, drain in order, clear ovf
    for (int i = 0; i < 4; i++) wr(3'(i), 15'(i + 1));
    check("t2_ovf_before", 32'(ovf), 32'(0));
    wr(3'd1, 15'd5);
    check("t2_ovf", 32'(ovf), 32'(1));
    rd("t2_chan1", 3'd1, 15'd5);
    check("t2_head", ev(out_sel, out_data), ev(3'd0, 15'd1));
    tick();
    check("t2_head_hold", ev(out_sel, out_data), ev(3'd0, 15'd1));
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    out_ready = 1'b0;
    check("t2_drained", 32'(out_valid), 32'(0));
    check("t2_ovf_sticky", 32'(ovf), 32'(1));
    ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
    check("t2_ovf_cleared", 32'(ovf), 32'(0));

    // Test 3: drop with simultaneous clear, then push into full FIFO on a pop
    for (int i = 0; i < 4; i++) wr(3'(i), 15'(10 + i));
    ovf_clear = 1'b1; wr(3'd2, 15'd9); ovf_clear = 1'b0;
    check("t3_set_wins", 32'(ovf), 32'(1));
    rd("t3_chan2", 3'd2, 15'd9);
    ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
    check("t3_ovf_cleared", 32'(ovf), 32'(0));
    out_ready = 1'b1; wr(3'd3, 15'd7); out_ready = 1'b0;
    check("t3_no_drop", 32'(ovf), 32'(0));
    check("t3_sb_depth", 32'(exp_q.size()), 32'(4));
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("t3_count4", 32'(out_valid), 32'(0));
    out_ready = 1'b0;

    // Test 4: same-channel collision stalls input; then input loads
    in_valid = 1'b1; in_sel = 3'd4; in_data = 15'o777;
    io_write_en = 1'b1; io_write_sel = 3'd4; io_write_data = 15'o111;
    #1;
    check("t4_in_stall", 32'(in_ready), 32'(0));
    tick();
    io_write_en = 1'b0;
    rd("t4_core_wins", 3'd4, 15'o111);
    check("t4_in_ready", 32'(in_ready), 32'(1));
    tick();
    in_valid = 1'b0;
    rd("t4_in_load", 3'd4, 15'o777);
    check("t4_no_event", 32'(out_valid), 32'(0));
    // different channels in the same cycle both land
    in_valid = 1'b1; in_sel = 3'd5; in_data = 15'o55;
    wr(3'd0, 15'o42);
    in_valid = 1'b0;
    rd("t4_both_core", 3'd0, 15'o42);
    rd("t4_both_in", 3'd5, 15'o55);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Test 5: input to unmasked channel discarded; write to non-out channel
    in_valid = 1'b1; in_sel = 3'd1; in_data = 15'd5;
    #1;
    check("t5_in_ready", 32'(in_ready), 32'(1));
    tick();
    in_valid = 1'b0;
    rd("t5_chan1_kept", 3'd1, 15'd11);
    wr(3'd6, 15'o606);
    rd("t5_chan6", 3'd6, 15'o606);
    check("t5_no_event", 32'(out_valid), 32'(0));

    // Test 6: asynchronous reset with 3 events queued and ovf set
    for (int i = 0; i < 5; i++) wr(3'(i % 4), 15'(20 + i));
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("t6_pre_ovf", 32'(ovf), 32'(1));
    check("t6_pre_depth", 32'(exp_q.size()), 32'(3));
    #2;
    rst_l = 1'b0;
    exp_q.delete();
    #1;
    check("t6_out_valid", 32'(out_valid), 32'(0));
    check("t6_ovf", 32'(ovf), 32'(0));
    check("t6_head", ev(out_sel, out_data), 32'(0));
    for (int i = 0; i < 6; i++) begin
      io_read_sel = 3'(i);
      #0.5;
      check("t6_chan", 32'(io_read_data), 32'(0));
    end
    rd("t6_chan6", 3'd6, 15'd0);
    rd("t6_chan7", 3'd7, 15'd0);
    rst_l = 1'b1;
    tick();
    check("t6_after", 32'(out_valid), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
